// File: rtl/edge_pkg.sv
// edge_pkg: channel state encoding, mode codes and tick decode for multi_edge_detect
package edge_pkg;
  typedef enum logic [1:0] {ZERO = 2'b00, RISE = 2'b01, ONE = 2'b10, FALL = 2'b11} state_t;
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;
  function automatic logic tick_of(state_t s, logic [1:0] m);
    return m != MODE_OFF &&
           ((s == RISE && (m == MODE_RISE || m == MODE_BOTH)) ||
            (s == FALL && (m == MODE_FALL || m == MODE_BOTH)));
  endfunction
endpackage

// File: rtl/edge_chan.sv
// edge_chan: one debounced Moore edge FSM with sticky pending flag
module edge_chan
  import edge_pkg::*;
#(
  parameter int STABLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       level,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       tick,
  output logic       pending
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic hunt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= ZERO;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pending <= tick | (pending & ~clear);
    end
  // hunt: level disagrees with the settled state, so the debounce counter runs
  always_comb begin
    state_nx = ZERO;
    hunt = (state == ZERO && level) || (state == ONE && !level);
    case (state)
      ZERO:    state_nx = (level && cnt == LAST) ? RISE : ZERO;
      RISE:    state_nx = ONE;
      ONE:     state_nx = (!level && cnt == LAST) ? FALL : ONE;
      FALL:    state_nx = ZERO;
      default: state_nx = ZERO;
    endcase
    cnt_nx = (hunt && cnt != LAST) ? cnt + 1'b1 : '0;
  end
  assign tick = tick_of(state, mode);
endmodule

// File: rtl/multi_edge_detect.sv
// multi_edge_detect: CH debounced edge detectors; MULTI_EDGE_SYNC_EN adds a 2-flop input synchroniser
module multi_edge_detect #(
  parameter int CH            = 4,
  parameter int STABLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [CH-1:0]   level,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clear,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   pending,
  output logic            any_tick
);
  logic [CH-1:0] lv;
`ifdef MULTI_EDGE_SYNC_EN
  logic [CH-1:0] s1, s2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= level;
      s2 <= s1;
    end
  assign lv = s2;
`else
  assign lv = level;
`endif
  for (genvar g = 0; g < CH; g++) begin : chan
    edge_chan #(.STABLE_CYCLES(STABLE_CYCLES)) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .level   (lv[g]),
      .mode    (mode[2*g +: 2]),
      .clear   (clear[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end
  assign any_tick = |tick;
endmodule

// File: tb/tb_multi_edge_detect.sv
// tb_multi_edge_detect: randomized and directed checks against a behavioural debounce/edge model
module tb_multi_edge_detect;
  localparam int CH = 4;
`ifdef MULTI_EDGE_SYNC_EN
  localparam int SC = 1;
  localparam int LAT = 2;
`else
  localparam int SC = 3;
  localparam int LAT = 0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [CH-1:0] level = '0;
  logic [CH-1:0] clear = '0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0] tick, pending;
  logic any_tick;
  int n_chk = 0;
  int n_fail = 0;
  int run[CH];
  bit acc[CH], trans[CH], dir[CH], pend[CH];
  logic [CH-1:0] d1 = '0;
  logic [CH-1:0] d2 = '0;

  multi_edge_detect #(.CH(CH), .STABLE_CYCLES(SC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .level    (level),
    .mode     (mode),
    .clear    (clear),
    .tick     (tick),
    .pending  (pending),
    .any_tick (any_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] exp_tick();
    logic [CH-1:0] e;
    for (int i = 0; i < CH; i++) e[i] = trans[i] && (dir[i] ? mode[2*i] : mode[2*i+1]);
    return e;
  endfunction

  function automatic logic [CH-1:0] exp_pend();
    logic [CH-1:0] p;
    for (int i = 0; i < CH; i++) p[i] = pend[i];
    return p;
  endfunction

  initial forever begin
    logic [CH-1:0] et;
    bit x;
    @(negedge clk);
    if (!reset_n) begin
      chk("reset_tick", tick, 0);
      chk("reset_pending", pending, 0);
      chk("reset_any", any_tick, 0);
      for (int i = 0; i < CH; i++) begin
        run[i] = 0; acc[i] = 0; trans[i] = 0; dir[i] = 0; pend[i] = 0;
      end
      d1 = '0;
      d2 = '0;
    end else begin
      et = exp_tick();
      chk("tick", tick, et);
      chk("pending", pending, exp_pend());
      chk("any_tick", any_tick, |et);
      for (int i = 0; i < CH; i++) begin
        x = LAT > 0 ? d2[i] : level[i];
        pend[i] = et[i] ? 1'b1 : clear[i] ? 1'b0 : pend[i];
        if (trans[i]) begin
          trans[i] = 0;
          run[i] = 0;
        end else if (x != acc[i]) begin
          run[i]++;
          if (run[i] == SC) begin
            acc[i] = x; trans[i] = 1; dir[i] = x; run[i] = 0;
          end
        end else run[i] = 0;
      end
      d2 = d1;
      d1 = level;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    step(3);
    chk("por_tick", tick, 0);
    chk("por_pending", pending, 0);
    chk("por_any", any_tick, 0);
    reset_n = 1'b1;
    step(4);
    mode = 8'h55;
    level[0] = 1'b1;
    step(SC + LAT - 1);
    chk("rise_early", tick[0], 0);
    step();
    chk("rise_tick", tick, 4'b0001);
    chk("rise_any", any_tick, 1);
    step();
    chk("rise_once", tick[0], 0);
    chk("rise_pend", pending[0], 1);
    level[1] = 1'b1;
    step(SC - 1);
    level[1] = 1'b0;
    step(SC + LAT + 2);
    chk("glitch_tick", tick[1], 0);
    chk("glitch_pend", pending[1], 0);
    level[2] = 1'b1;
    step(SC + LAT + 2);
    clear[2] = 1'b1;
    step();
    clear[2] = 1'b0;
    chk("ch2_cleared", pending[2], 0);
    mode[5:4] = 2'b01;
    level[2] = 1'b0;
    step(SC + LAT);
    chk("fall_mode01", tick[2], 0);
    mode[5:4] = 2'b10;
    #1;
    chk("fall_mode10", tick[2], 1);
    chk("fall_any", any_tick, 1);
    step(2);
    chk("fall_pend", pending[2], 1);
    mode[7:6] = 2'b01;
    level[3] = 1'b1;
    step(SC + LAT);
    chk("ch3_tick", tick[3], 1);
    clear[3] = 1'b1;
    step();
    chk("set_wins", pending[3], 1);
    step();
    chk("clear_after", pending[3], 0);
    clear[3] = 1'b0;
    level = '0;
    step(SC + LAT + 4);
    level[0] = 1'b1;
    step(SC + LAT - 1);
    reset_n = 1'b0;
    #1;
    chk("abort_tick", tick, 0);
    chk("abort_pend", pending, 0);
    step();
    reset_n = 1'b1;
    step(SC + LAT - 1);
    chk("rel_early", tick[0], 0);
    step();
    chk("rel_tick", tick[0], 1);
    level = '0;
    mode = 8'hFF;
    step(SC + LAT + 4);
    level = 4'hF;
    step(SC + LAT);
    chk("all_tick", tick, 4'hF);
    chk("all_any", any_tick, 1);
    step();
    chk("all_once", tick, 0);
    chk("all_any_once", any_tick, 0);
    repeat (3000) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(5) == 0) level[i] = ~level[i];
        clear[i] = $urandom_range(7) == 0;
      end
      if ($urandom_range(15) == 0) mode = 8'($urandom);
      reset_n = $urandom_range(299) != 0;
      step();
    end
    reset_n = 1'b1;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
